// File: rtl/speed_meter_pkg.sv
// Shared types and elaboration helpers for the encoder speed meter.
package speed_meter_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_e;

    function automatic int unsigned calc_ms_div(input int unsigned sys_freq);
        return sys_freq / 32'd1000;
    endfunction

    // Full product width so the multiply never truncates before the shift.
    function automatic int unsigned calc_prod_w(input int unsigned width_tik,
                                                input int unsigned speed_mul);
        return width_tik + $clog2(speed_mul + 32'd1);
    endfunction

    function automatic logic [31:0] sat_u32(input logic [31:0] value,
                                            input logic [31:0] limit);
        if (value > limit) begin
            return limit;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/speed_meter_timebase.sv
// Millisecond prescaler and window counter; win_end_o marks the last clock of each window.
module speed_meter_timebase
    import speed_meter_pkg::*;
#(
    parameter int unsigned MS_DIV    = 32'd10000,
    parameter int unsigned WINDOW_MS = 32'd100,
    parameter int unsigned WIDTH_MS  = 32'd14
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic ms_tick_o,
    output logic win_end_o
);

    localparam int unsigned PRE_W = (MS_DIV > 32'd1) ? $clog2(MS_DIV) : 32'd1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(MS_DIV - 32'd1);
    localparam logic [WIDTH_MS-1:0] MS_LAST  = WIDTH_MS'(WINDOW_MS - 32'd1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [WIDTH_MS-1:0] ms_q, ms_d;
    logic                ms_tick_s;
    logic                win_end_s;

    // Next-state for prescaler and ms counter, plus wrap decode
    always_comb begin
        ms_tick_s = (pre_q == PRE_LAST);
        win_end_s = ms_tick_s && (ms_q == MS_LAST);
        pre_d     = pre_q + PRE_W'(1'b1);
        ms_d      = ms_q;
        if (ms_tick_s) begin
            pre_d = '0;
            if (ms_q == MS_LAST) begin
                ms_d = '0;
            end else begin
                ms_d = ms_q + WIDTH_MS'(1'b1);
            end
        end else begin
            ms_d = ms_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

    assign ms_tick_o = ms_tick_s;
    assign win_end_o = win_end_s;

endmodule

// File: rtl/speed_meter.sv
// Encoder speed meter: counts synchronized rising edges per window and delivers a scaled speed word.
// Optional input glitch filter enabled by defining SPEED_METER_FILTER_EN.
module speed_meter
    import speed_meter_pkg::*;
#(
    parameter int unsigned SYS_FREQ    = 32'd10000000,
    parameter int unsigned WIDTH_TIK   = 32'd16,
    parameter int unsigned WIDTH_MS    = 32'd14,
    parameter int unsigned WIDTH_SPEED = 32'd14,
    parameter int unsigned WINDOW_MS   = 32'd100,
    parameter int unsigned SPEED_MUL   = 32'd15,
    parameter int unsigned SPEED_SHIFT = 32'd3,
    parameter int unsigned FILTER_LEN  = 32'd4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enc_in,
    input  logic                   busy,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   done,
    output logic                   overrun
);

    localparam int unsigned MS_DIV = calc_ms_div(SYS_FREQ);
    localparam int unsigned PROD_W = calc_prod_w(WIDTH_TIK, SPEED_MUL);
    localparam logic [31:0] SPEED_MAX = (32'd1 << WIDTH_SPEED) - 32'd1;

    if ((WINDOW_MS < 32'd1) || ((WINDOW_MS * MS_DIV) <= 32'd2)) begin : g_bad_window
        $error("speed_meter: window must span more than two clocks");
    end
    if (FILTER_LEN < 32'd1) begin : g_bad_filter
        $error("speed_meter: FILTER_LEN must be at least 1");
    end

    logic                   sync1_q, sync2_q;
    logic                   level_s, level_prev_q;
    logic                   tick_evt_s;
    logic                   ms_tick_s, tb_win_end_s, win_end_s;
    logic [WIDTH_TIK-1:0]   tick_cnt_q, tick_cnt_d, tick_inc_s;
    logic [WIDTH_TIK-1:0]   snapshot_q, snapshot_d;
    logic [PROD_W-1:0]      prod_s, shifted_s;
    logic [WIDTH_SPEED-1:0] calc_s;
    state_e                 state_q, state_d;
    logic [WIDTH_SPEED-1:0] result_q, result_d;
    logic                   pending_q, pending_d;
    logic [WIDTH_SPEED-1:0] speed_q, speed_d;
    logic                   done_s, overrun_s;

    speed_meter_timebase #(
        .MS_DIV    (MS_DIV),
        .WINDOW_MS (WINDOW_MS),
        .WIDTH_MS  (WIDTH_MS)
    ) u_timebase (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .ms_tick_o (ms_tick_s),
        .win_end_o (tb_win_end_s)
    );

    assign win_end_s = ms_tick_s && tb_win_end_s;

    // Two-flop synchronizer for the asynchronous encoder input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= enc_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SPEED_METER_FILTER_EN
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 32'd1);

    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             flt_lvl_q, flt_lvl_d;

    // Level flips only after FILTER_LEN consecutive samples disagree with it
    always_comb begin
        flt_cnt_d = '0;
        flt_lvl_d = flt_lvl_q;
        if (sync2_q != flt_lvl_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 32'd1)) begin
                flt_lvl_d = sync2_q;
                flt_cnt_d = '0;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1'b1);
            end
        end else begin
            flt_cnt_d = '0;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_cnt_q <= '0;
            flt_lvl_q <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            flt_lvl_q <= flt_lvl_d;
        end
    end

    assign level_s = flt_lvl_q;
`else
    assign level_s = sync2_q;
`endif

    assign tick_evt_s = level_s && !level_prev_q;

    // Edge counter; an edge on the closing cycle still belongs to that window
    always_comb begin
        tick_inc_s = tick_cnt_q;
        if (tick_evt_s && !(&tick_cnt_q)) begin
            tick_inc_s = tick_cnt_q + WIDTH_TIK'(1'b1);
        end else begin
            tick_inc_s = tick_cnt_q;
        end
        if (win_end_s) begin
            snapshot_d = tick_inc_s;
            tick_cnt_d = '0;
        end else begin
            snapshot_d = snapshot_q;
            tick_cnt_d = tick_inc_s;
        end
    end

    assign prod_s    = PROD_W'(snapshot_q) * PROD_W'(SPEED_MUL);
    assign shifted_s = prod_s >> SPEED_SHIFT;
    assign calc_s    = WIDTH_SPEED'(sat_u32(32'(shifted_s), SPEED_MAX));

    // FSM and delivery; a load in the delivery cycle keeps the new result pending
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        pending_d = pending_q;
        speed_d   = speed_q;
        done_s    = 1'b0;
        overrun_s = 1'b0;
        if (pending_q && !busy) begin
            done_s    = 1'b1;
            speed_d   = result_q;
            pending_d = 1'b0;
        end else begin
            speed_d   = speed_q;
        end
        case (state_q)
            S_IDLE: begin
                if (win_end_s) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                result_d  = calc_s;
                pending_d = 1'b1;
                overrun_s = pending_q && busy;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and FSM registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_prev_q <= 1'b0;
            tick_cnt_q   <= '0;
            snapshot_q   <= '0;
            state_q      <= S_IDLE;
            result_q     <= '0;
            pending_q    <= 1'b0;
            speed_q      <= '0;
        end else begin
            level_prev_q <= level_s;
            tick_cnt_q   <= tick_cnt_d;
            snapshot_q   <= snapshot_d;
            state_q      <= state_d;
            result_q     <= result_d;
            pending_q    <= pending_d;
            speed_q      <= speed_d;
        end
    end

    assign done    = done_s;
    assign speed   = done_s ? result_q : speed_q;
    assign overrun = overrun_s;

endmodule

// File: tb/tb_speed_meter.sv
// Directed bench for speed_meter: 10-clock ms, 1000-clock window, plus two narrow-width variants.
module tb_speed_meter;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enc_in  = 1'b0;
    logic busy    = 1'b0;

    logic [13:0] speed_a;
    logic        done_a, ovr_a;
    logic [7:0]  speed_b;
    logic        done_b, ovr_b;
    logic [13:0] speed_c;
    logic        done_c, ovr_c;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;
    int done_base;
    int exp_glitch;

    always #5 clk = ~clk;

    speed_meter #(.SYS_FREQ(10000)) u_dut (
        .clk(clk), .reset_n(reset_n), .enc_in(enc_in), .busy(busy),
        .speed(speed_a), .done(done_a), .overrun(ovr_a)
    );

    speed_meter #(.SYS_FREQ(10000), .WIDTH_SPEED(8)) u_dut_ws (
        .clk(clk), .reset_n(reset_n), .enc_in(enc_in), .busy(busy),
        .speed(speed_b), .done(done_b), .overrun(ovr_b)
    );

    speed_meter #(.SYS_FREQ(10000), .WIDTH_TIK(8)) u_dut_wt (
        .clk(clk), .reset_n(reset_n), .enc_in(enc_in), .busy(busy),
        .speed(speed_c), .done(done_c), .overrun(ovr_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; cyc n means "sampled 1 time unit after edge n since reset release"
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done_a === 1'b1) done_cnt++;
        if (ovr_a === 1'b1) ovr_cnt++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            enc_in = 1'b1;
            repeat (hi) tick();
            enc_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        check_val("rst_speed", speed_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_overrun", ovr_a, 0);
        reset_n  = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        ovr_cnt  = 0;

        // 1: 160 edges, done exactly at W+2 (window ends on cyc 999)
        wait_to(10);
        pulses(160, 2, 2);
        wait_to(1000);
        check_val("t1_not_early", done_a, 0);
        check_val("t1_speed_hold", speed_a, 0);
        tick();
        check_val("t1_done", done_a, 1);
        check_val("t1_speed", speed_a, 300);
        check_val("t1_sat_w8", speed_b, 255);
        check_val("t1_no_overrun", ovr_a, 0);
        tick();
        check_val("t1_strobe_len", done_a, 0);
        check_val("t1_speed_kept", speed_a, 300);

        // 2: empty window, then 8 edges
        wait_to(2001);
        check_val("t2_zero_done", done_a, 1);
        check_val("t2_zero_speed", speed_a, 0);
        wait_to(2100);
        pulses(8, 2, 2);
        wait_to(3001);
        check_val("t2_eight_done", done_a, 1);
        check_val("t2_eight_speed", speed_a, 15);

        // 3: busy across two window ends
        tick();
        busy      = 1'b1;
        done_base = done_cnt;
        check_val("t3_no_ovr_before", ovr_cnt, 0);
        wait_to(3100);
        pulses(16, 2, 2);
        wait_to(4001);
        check_val("t3_blocked", done_a, 0);
        check_val("t3_speed_held1", speed_a, 15);
        wait_to(4100);
        pulses(24, 2, 2);
        wait_to(5000);
        check_val("t3_ovr_pulse", ovr_a, 1);
        tick();
        check_val("t3_ovr_single", ovr_a, 0);
        wait_to(5010);
        check_val("t3_no_done", done_cnt - done_base, 0);
        check_val("t3_ovr_count", ovr_cnt, 1);
        check_val("t3_speed_held2", speed_a, 15);
        busy = 1'b0;
        #1;
        check_val("t3_release_done", done_a, 1);
        check_val("t3_release_speed", speed_a, 45);
        tick();
        check_val("t3_release_once", done_a, 0);
        check_val("t3_release_kept", speed_a, 45);

        // 4: toggle every clock -> 500 edges in window ending cyc 6999
        wait_to(5020);
        while (cyc < 7001) begin
            enc_in = ~enc_in;
            tick();
        end
        enc_in = 1'b0;
        check_val("t4_done", done_a, 1);
        check_val("t4_speed_full", speed_a, 937);
        check_val("t4_sat_speed", speed_b, 255);
        check_val("t4_sat_ticks", speed_c, 478);

        // 5: ninth+1 edge lands on the closing cycle (tick at cyc 8999)
        wait_to(8100);
        pulses(9, 2, 2);
        wait_to(8997);
        enc_in = 1'b1;
        wait_to(9001);
        check_val("t5_edge_done", done_a, 1);
        check_val("t5_edge_speed", speed_a, 18);
        check_val("t5_edge_speed_w8t", speed_c, 18);
        enc_in  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_speed", speed_a, 0);
        check_val("t5_rst_done", done_a, 0);
        repeat (4) tick();
        reset_n  = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        wait_to(100);
        pulses(8, 2, 2);
        wait_to(1000);
        check_val("t5_no_early_done", done_cnt, 0);
        tick();
        check_val("t5_first_done", done_a, 1);
        check_val("t5_first_speed", speed_a, 15);

        // 6: short glitches (filtered only when the filter is built in), then wide pulses
`ifdef SPEED_METER_FILTER_EN
        exp_glitch = 0;
`else
        exp_glitch = 37;
`endif
        wait_to(1100);
        pulses(20, 2, 4);
        wait_to(2001);
        check_val("t6_glitch_done", done_a, 1);
        check_val("t6_glitch_speed", speed_a, exp_glitch);
        wait_to(2100);
        pulses(10, 10, 10);
        wait_to(3001);
        check_val("t6_wide_speed", speed_a, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
